fetch_bpred: RTL and testbench

FETCH_BPRED -- requirements
Module: fetch_bpred

---
 rtl/bpred_pkg.sv | 15 +
 rtl/fetch_bpred_if.sv | 25 ++
 rtl/bpred_sat_ctr.sv | 21 ++
 rtl/fetch_bpred.sv | 127 ++++++++++++
 tb/tb_fetch_bpred.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bpred_pkg.sv
// Shared types for the fetch branch predictor: 2-bit saturating counter
// encoding and its reset and allocation values.
package bpred_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_INIT  = WNT;
    localparam ctr_t CTR_ALLOC = WT;

endpackage

// File: rtl/fetch_bpred_if.sv
// Fetch/execute-side signal bundle of the branch predictor. master is the
// pipeline side, slave is the predictor side.
interface fetch_bpred_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PCF;
    logic            StallF;
    logic            BP;
    logic [XLEN-1:0] PredPCF;
    logic            UpdateE;
    logic [XLEN-1:0] PCE;
    logic            TakenE;
    logic [XLEN-1:0] TargetE;
    logic            MispredE;

    modport master (
        output PCF, StallF, UpdateE, PCE, TakenE, TargetE, MispredE,
        input  BP, PredPCF
    );

    modport slave (
        input  PCF, StallF, UpdateE, PCE, TakenE, TargetE, MispredE,
        output BP, PredPCF
    );
endinterface

// File: rtl/bpred_sat_ctr.sv
// Combinational next state of a 2-bit saturating taken/not-taken counter.
module bpred_sat_ctr
    import bpred_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/fetch_bpred.sv
// Direct-mapped fetch branch predictor with zero-latency lookup and one-cycle
// update. Define BPRED_STATS_EN to add the LookupCnt/MispredCnt counters.
module fetch_bpred
    import bpred_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    input  logic            StallF,
    output logic            BP,
    output logic [XLEN-1:0] PredPCF,
    input  logic            UpdateE,
    input  logic [XLEN-1:0] PCE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            MispredE
`ifdef BPRED_STATS_EN
   ,output logic [31:0]     LookupCnt
   ,output logic [31:0]     MispredCnt
`endif
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic            valid_q [ENTRIES];
    logic            valid_d [ENTRIES];
    ctr_t            ctr_q   [ENTRIES];
    ctr_t            ctr_d   [ENTRIES];
    logic [TAGW-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0] tgt_q   [ENTRIES];

    logic [IDX-1:0]  idx_f, idx_e;
    logic [TAGW-1:0] tag_f, tag_e;
    logic            hit_f, hit_e;
    ctr_t            ctr_nxt;

    assign idx_f = PCF[IDX+1:2];
    assign tag_f = PCF[XLEN-1:IDX+2];
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[XLEN-1:IDX+2];

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign BP      = hit_f && (ctr_q[idx_f] inside {WT, ST});
    assign PredPCF = BP ? tgt_q[idx_f] : PCF + XLEN'(4);

    bpred_sat_ctr u_sat_ctr (
        .cur   (ctr_q[idx_e]),
        .taken (TakenE),
        .nxt   (ctr_nxt)
    );

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        if (UpdateE) begin
            if (hit_e) begin
                ctr_d[idx_e] = ctr_nxt;
            end else if (TakenE) begin
                valid_d[idx_e] = 1'b1;
                ctr_d[idx_e]   = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Any taken resolution carries the entry's tag and target: a rewrite on
    // a hit, fresh contents on an allocation. Invalid entries are never read.
    always_ff @(posedge clk) begin
        if (UpdateE && TakenE) begin
            tag_q[idx_e] <= tag_e;
            tgt_q[idx_e] <= TargetE;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] lookup_cnt_q, lookup_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!StallF && (lookup_cnt_q != 32'hFFFF_FFFF)) begin
            lookup_cnt_d = lookup_cnt_q + 32'd1;
        end
        if (UpdateE && MispredE && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign LookupCnt  = lookup_cnt_q;
    assign MispredCnt = mispred_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{StallF, MispredE};
`endif

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{PCF[1:0], PCE[1:0]};

endmodule

// File: tb/tb_fetch_bpred.sv
// Self-checking bench for fetch_bpred against an array-based predictor model.
module tb_fetch_bpred;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_bpred_if #(.XLEN(32)) bif ();

`ifdef BPRED_STATS_EN
    logic [31:0] LookupCnt, MispredCnt;
`endif

    fetch_bpred #(.ENTRIES(64), .XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .PCF      (bif.PCF),
        .StallF   (bif.StallF),
        .BP       (bif.BP),
        .PredPCF  (bif.PredPCF),
        .UpdateE  (bif.UpdateE),
        .PCE      (bif.PCE),
        .TakenE   (bif.TakenE),
        .TargetE  (bif.TargetE),
        .MispredE (bif.MispredE)
`ifdef BPRED_STATS_EN
       ,.LookupCnt  (LookupCnt)
       ,.MispredCnt (MispredCnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: 64 entries, index = word address mod 64, tag = PC / 256.
    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    logic [31:0] m_look, m_mis;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_pred(input logic [31:0] pc, output logic bp, output logic [31:0] npc);
        int i;
        i   = int'((pc >> 2) % 64);
        bp  = m_valid[i] && (m_tag[i] == 24'(pc >> 8)) && (m_ctr[i] >= 2);
        npc = bp ? m_tgt[i] : pc + 32'd4;
    endfunction

    always @(posedge clk or negedge reset) begin : model_upd
        int i;
        bit hit;
        if (!reset) begin
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_look = 32'd0;
            m_mis  = 32'd0;
        end else begin
            if (!bif.StallF && m_look != 32'hFFFF_FFFF) m_look = m_look + 32'd1;
            if (bif.UpdateE && bif.MispredE && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
            if (bif.UpdateE) begin
                i   = int'((bif.PCE >> 2) % 64);
                hit = m_valid[i] && (m_tag[i] == 24'(bif.PCE >> 8));
                if (hit) begin
                    if (bif.TakenE) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = bif.TargetE;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (bif.TakenE) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = 24'(bif.PCE >> 8);
                    m_tgt[i]   = bif.TargetE;
                    m_ctr[i]   = 2;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        e_bp;
        logic [31:0] e_pc;
        if (chk_en) begin
            #2;
            model_pred(bif.PCF, e_bp, e_pc);
            check("bp", {31'd0, bif.BP}, {31'd0, e_bp});
            check("pred_pc", bif.PredPCF, e_pc);
`ifdef BPRED_STATS_EN
            check("lookup_cnt", LookupCnt, m_look);
            check("mispred_cnt", MispredCnt, m_mis);
`endif
        end
    end

    task automatic drive(input logic rst, input logic [31:0] pcf, input logic stall,
                         input logic upd, input logic [31:0] pce, input logic tk,
                         input logic [31:0] tgt, input logic mis);
        @(negedge clk);
        reset        = rst;
        bif.PCF      = pcf;
        bif.StallF   = stall;
        bif.UpdateE  = upd;
        bif.PCE      = pce;
        bif.TakenE   = tk;
        bif.TargetE  = tgt;
        bif.MispredE = mis;
    endtask

    task automatic lit(input string nm, input logic exp_bp, input logic [31:0] exp_pc);
        #3;
        check({nm, "_bp"}, {31'd0, bif.BP}, {31'd0, exp_bp});
        check({nm, "_pc"}, bif.PredPCF, exp_pc);
    endtask

    initial begin
        reset        = 1'b0;
        bif.PCF      = 32'h100;
        bif.StallF   = 1'b0;
        bif.UpdateE  = 1'b0;
        bif.PCE      = 32'h0;
        bif.TakenE   = 1'b0;
        bif.TargetE  = 32'h0;
        bif.MispredE = 1'b0;
        chk_en       = 1'b1;

        // Updates presented while reset is held must not allocate.
        repeat (3) drive(1'b0, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0);
        lit("in_reset", 1'b0, 32'h104);

        // Release with an update in the same cycle: old view now, new next cycle.
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        lit("after_reset", 1'b0, 32'h104);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lit("alloc", 1'b1, 32'h200);
        drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lit("tag_miss", 1'b0, 32'h204);
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lit("pc_wrap", 1'b0, 32'h0);

        // Counter walk: WT -> WNT -> SNT, then taken x4 to ST, then back down.
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        lit("ctr_wt", 1'b1, 32'h200);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        lit("ctr_wnt", 1'b0, 32'h104);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        lit("ctr_snt", 1'b0, 32'h104);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        lit("ctr_up_wt", 1'b1, 32'h200);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        lit("ctr_st_held", 1'b1, 32'h200);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lit("ctr_down_wnt", 1'b0, 32'h104);

`ifdef BPRED_STATS_EN
        drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'h100, 1'b0, (c % 3 == 1), 32'h400, 1'b0, 32'h0, (c % 3 == 1));
        end
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #3;
        check("stats_lookup10", LookupCnt, 32'd10);
        check("stats_mispred3", MispredCnt, 32'd3);
        drive(1'b0, 32'h100, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
        #3;
        check("stats_rst_lookup", LookupCnt, 32'd0);
        check("stats_rst_mispred", MispredCnt, 32'd0);
`endif

        // Random traffic over a few colliding indices and tags.
        for (int c = 0; c < 800; c++) begin
            logic [31:0] pcf, pce, tgt;
            logic        rst;
            pcf = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
            pce = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 3) == 0) pcf = pcf | 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) pce = pce | 32'h8000_0000;
            tgt = $urandom & 32'hFFFF_FFFC;
            rst = ($urandom_range(0, 149) != 0);
            drive(rst, pcf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pce,
                  1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)));
        end

        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #4;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
